// File: rtl/sample_frame_buffer.sv
// Ping-pong frame buffer: serial valid/ready sample input, flattened parallel frame output.
// Optional macro SAMPLE_FRAME_BUFFER_BITREV_EN stores samples in bit-reversed address order.
module sample_frame_buffer #(
    parameter  int N     = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N-1:0]       i_word,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_flush,
    output logic [N*DEPTH-1:0] o_frame,
    output logic               o_frame_valid,
    input  logic               i_frame_ack,
    output logic [AW:0]        o_fill,
    output logic               o_overflow
);

    // Storage address for a write pointer; bit-reversed order feeds a radix-2 DIT FFT directly.
    function automatic logic [AW-1:0] f_addr(input logic [AW-1:0] p);
        logic [AW-1:0] a;
        a = '0;
`ifdef SAMPLE_FRAME_BUFFER_BITREV_EN
        for (int i = 0; i < AW; i++) begin
            a[i] = p[AW-1-i];
        end
`else
        a = p;
`endif
        return a;
    endfunction

    logic [1:0][DEPTH-1:0][N-1:0] r_mem;
    logic [1:0]                   r_full;
    logic                         r_wr_bank;
    logic                         r_rd_bank;
    logic [AW-1:0]                r_wr_ptr;
    logic                         r_overflow;

    logic w_accept;
    logic w_ack;
    logic w_last;

    assign o_ready       = ~r_full[r_wr_bank];
    assign o_frame_valid = r_full[r_rd_bank];
    assign o_frame       = r_mem[r_rd_bank];
    assign o_fill        = {1'b0, r_wr_ptr};
    assign o_overflow    = r_overflow;

    assign w_accept = i_valid & o_ready;
    assign w_ack    = i_frame_ack & o_frame_valid;
    assign w_last   = (r_wr_ptr == AW'(DEPTH - 1));

    // Sample storage; flush leaves contents untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '0;
        end else if (w_accept && !i_flush) begin
            r_mem[r_wr_bank][f_addr(r_wr_ptr)] <= i_word;
        end else begin
            r_mem <= r_mem;
        end
    end

    // Bank status, pointers and sticky overflow. The write bank is always EMPTY and the
    // ack bank always FULL, so a final write and an ack never touch the same status bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_last) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                    r_wr_ptr          <= '0;
                end else begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
            end
            if (w_ack) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            if (i_valid && !o_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Directed self-checking bench for sample_frame_buffer (N=16, DEPTH=16).
module tb_sample_frame_buffer;

    logic         i_clk;
    logic         i_rst_n;
    logic [15:0]  i_word;
    logic         i_valid;
    logic         o_ready;
    logic         i_flush;
    logic [255:0] o_frame;
    logic         o_frame_valid;
    logic         i_frame_ack;
    logic [4:0]   o_fill;
    logic         o_overflow;

    int total = 0;
    int bad   = 0;

    sample_frame_buffer #(.N(16), .DEPTH(16)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_word        (i_word),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_flush       (i_flush),
        .o_frame       (o_frame),
        .o_frame_valid (o_frame_valid),
        .i_frame_ack   (i_frame_ack),
        .o_fill        (o_fill),
        .o_overflow    (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Expected frame when samples base, base+1, ... base+15 fill one bank.
    function automatic logic [255:0] exp_frame(input logic [15:0] base);
        logic [255:0] f;
        logic [3:0]   k4;
        logic [3:0]   idx;
        f = '0;
        for (int k = 0; k < 16; k++) begin
            k4 = 4'(k);
`ifdef SAMPLE_FRAME_BUFFER_BITREV_EN
            idx = {k4[0], k4[1], k4[2], k4[3]};
`else
            idx = k4;
`endif
            f[idx*16 +: 16] = base + 16'(k);
        end
        return f;
    endfunction

    task automatic send(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_word  = base + 16'(i);
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic ack_once();
        i_frame_ack = 1'b1;
        @(posedge i_clk); #1;
        i_frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_frame_ack = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_frame_ack = 1'b0; i_word = 16'h0000;
        #3;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        total++; if (o_frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fvalid got=%b exp=0", o_frame_valid); end
        total++; if (o_frame !== 256'd0) begin bad++; $display("FAIL reset_frame got=%h exp=0", o_frame); end
        total++; if (o_fill !== 5'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", o_fill); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", o_overflow); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_fill();
        logic [15:0] w1;
        logic [15:0] w8;
        do_reset();
        send(15, 16'h0001);
        total++; if (o_frame_valid !== 1'b0) begin bad++; $display("FAIL fill_early_fvalid got=%b exp=0", o_frame_valid); end
        total++; if (o_fill !== 5'd15) begin bad++; $display("FAIL fill_count got=%0d exp=15", o_fill); end
        send(1, 16'h0010);
        total++; if (o_frame_valid !== 1'b1) begin bad++; $display("FAIL fill_fvalid got=%b exp=1", o_frame_valid); end
        total++; if (o_frame !== exp_frame(16'h0001)) begin bad++; $display("FAIL fill_frame got=%h exp=%h", o_frame, exp_frame(16'h0001)); end
        w1 = o_frame[16 +: 16];
        w8 = o_frame[128 +: 16];
`ifdef SAMPLE_FRAME_BUFFER_BITREV_EN
        total++; if (w1 !== 16'h0009) begin bad++; $display("FAIL fill_word1 got=%h exp=0009", w1); end
        total++; if (w8 !== 16'h0002) begin bad++; $display("FAIL fill_word8 got=%h exp=0002", w8); end
`else
        total++; if (w1 !== 16'h0002) begin bad++; $display("FAIL fill_word1 got=%h exp=0002", w1); end
        total++; if (w8 !== 16'h0009) begin bad++; $display("FAIL fill_word8 got=%h exp=0009", w8); end
`endif
        total++; if (o_fill !== 5'd0) begin bad++; $display("FAIL fill_wrap got=%0d exp=0", o_fill); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL fill_ready got=%b exp=1", o_ready); end
        ack_once();
        total++; if (o_frame_valid !== 1'b0) begin bad++; $display("FAIL fill_ack_fvalid got=%b exp=0", o_frame_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        send(32, 16'h0101);
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", o_ready); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf_early got=%b exp=0", o_overflow); end
        send(8, 16'h0121);
        total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b exp=1", o_overflow); end
        total++; if (o_fill !== 5'd0) begin bad++; $display("FAIL bp_fill got=%0d exp=0", o_fill); end
        total++; if (o_frame !== exp_frame(16'h0101)) begin bad++; $display("FAIL bp_frame0 got=%h exp=%h", o_frame, exp_frame(16'h0101)); end
        ack_once();
        total++; if (o_frame_valid !== 1'b1) begin bad++; $display("FAIL bp_fvalid got=%b exp=1", o_frame_valid); end
        total++; if (o_frame !== exp_frame(16'h0111)) begin bad++; $display("FAIL bp_frame1 got=%h exp=%h", o_frame, exp_frame(16'h0111)); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", o_ready); end
        total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf_sticky got=%b exp=1", o_overflow); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        send(16, 16'h0200);
        send(15, 16'h0210);
        i_valid = 1'b1; i_word = 16'h021F; i_frame_ack = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_frame_ack = 1'b0;
        total++; if (o_frame_valid !== 1'b1) begin bad++; $display("FAIL sim_fvalid got=%b exp=1", o_frame_valid); end
        total++; if (o_frame !== exp_frame(16'h0210)) begin bad++; $display("FAIL sim_frame got=%h exp=%h", o_frame, exp_frame(16'h0210)); end
        total++; if (o_fill !== 5'd0) begin bad++; $display("FAIL sim_fill got=%0d exp=0", o_fill); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL sim_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_spurious_ack();
        do_reset();
        send(3, 16'h0300);
        ack_once();
        total++; if (o_frame_valid !== 1'b0) begin bad++; $display("FAIL spur_fvalid got=%b exp=0", o_frame_valid); end
        total++; if (o_fill !== 5'd3) begin bad++; $display("FAIL spur_fill got=%0d exp=3", o_fill); end
        send(13, 16'h0303);
        total++; if (o_frame_valid !== 1'b1) begin bad++; $display("FAIL spur_fvalid2 got=%b exp=1", o_frame_valid); end
        total++; if (o_frame !== exp_frame(16'h0300)) begin bad++; $display("FAIL spur_frame got=%h exp=%h", o_frame, exp_frame(16'h0300)); end
    endtask

    task automatic test_flush();
        do_reset();
        send(33, 16'h0400);
        ack_once();
        send(7, 16'h0600);
        total++; if (o_fill !== 5'd7) begin bad++; $display("FAIL flush_pre_fill got=%0d exp=7", o_fill); end
        i_valid = 1'b1; i_word = 16'h06FF; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        total++; if (o_fill !== 5'd0) begin bad++; $display("FAIL flush_fill got=%0d exp=0", o_fill); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b exp=0", o_overflow); end
        total++; if (o_frame_valid !== 1'b0) begin bad++; $display("FAIL flush_fvalid got=%b exp=0", o_frame_valid); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", o_ready); end
        send(16, 16'h0500);
        total++; if (o_frame_valid !== 1'b1) begin bad++; $display("FAIL flush_fvalid2 got=%b exp=1", o_frame_valid); end
        total++; if (o_frame !== exp_frame(16'h0500)) begin bad++; $display("FAIL flush_frame got=%h exp=%h", o_frame, exp_frame(16'h0500)); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send(9, 16'h0701);
        total++; if (o_frame === 256'd0) begin bad++; $display("FAIL rmid_pre_frame got=%h exp=nonzero", o_frame); end
        #2;
        i_rst_n = 1'b0;
        #1;
        total++; if (o_fill !== 5'd0) begin bad++; $display("FAIL rmid_fill got=%0d exp=0", o_fill); end
        total++; if (o_frame !== 256'd0) begin bad++; $display("FAIL rmid_frame got=%h exp=0", o_frame); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", o_ready); end
        total++; if (o_frame_valid !== 1'b0) begin bad++; $display("FAIL rmid_fvalid got=%b exp=0", o_frame_valid); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_simultaneous();
        test_spurious_ack();
        test_flush();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_frame_buffer.md
# sample_frame_buffer

Parametrised, double-buffered (ping-pong) sample store that sits between the serial sample source and the parallel FFT core. It collects DEPTH words of width N serially through a valid/ready handshake. It presents each completed frame as one flattened parallel word with a valid/acknowledge handshake. Because it has two banks, the next frame loads while the FFT consumes the current one.

## Interface
Parameters:
- N, 16, sample word width in bits.
- DEPTH, 16, words per frame; must be a power of two and at least 2. AW = log2(DEPTH).

Ports:
- i_clk, input, 1, single clock; all state changes on the rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_word, input, N, input sample.
- i_valid, input, 1, i_word is valid this cycle.
- o_ready, output, 1, the write bank can accept a sample.
- i_flush, input, 1, synchronous clear of frame state; contents are kept.
- o_frame, output, N*DEPTH, frame of the read bank; word k is at bits [k*N +: N].
- o_frame_valid, output, 1, the read bank holds a complete frame.
- i_frame_ack, input, 1, the consumer has taken o_frame.
- o_fill, output, AW+1, number of words accepted into the current write bank.
- o_overflow, output, 1, sticky flag: a sample was offered while o_ready was 0.

## Operation
- Storage: two banks, each DEPTH×N registers. Each bank has a status bit, EMPTY or FULL.
- Pointers: wr_bank, rd_bank (1 bit each) and wr_ptr (AW bits).
- Write accept: a sample is accepted when i_valid && o_ready.
  - On accept, the sample is stored at bank[wr_bank][addr(wr_ptr)] and wr_ptr increments.
  - When wr_ptr == DEPTH-1 at accept: bank[wr_bank] becomes FULL, wr_bank toggles and wr_ptr wraps to 0.
- o_ready = status[wr_bank] == EMPTY.
- o_fill = wr_ptr, zero-extended to AW+1 bits.
- Read side:
  - o_frame_valid = status[rd_bank] == FULL.
  - o_frame = contents of bank[rd_bank], muxed from the storage registers.
- Acknowledge: i_frame_ack while o_frame_valid sets status[rd_bank] to EMPTY and toggles rd_bank. i_frame_ack while !o_frame_valid is ignored.
- Overflow: i_valid && !o_ready sets o_overflow. The sample is dropped. The flag clears only on reset or i_flush.
- Simultaneous events:
  - Completing the final write of one bank and acking the other bank in the same cycle: both take effect.
  - Completing the final write of a bank while rd_bank points at that same bank: o_frame_valid rises next cycle.
- i_flush has priority over write and ack in the same cycle. It sets both status bits to EMPTY, wr_bank = rd_bank = 0, wr_ptr = 0 and o_overflow = 0. Bank contents are unchanged.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Both banks EMPTY; all storage 0; pointers 0.
  - o_ready = 1, o_frame_valid = 0, o_frame = 0, o_fill = 0, o_overflow = 0.
- Throughput: one sample per cycle with no bubbles. Two frames can be buffered while no ack arrives.
- Write-to-frame latency: if the last sample of a frame is accepted at edge k, o_frame_valid is high in the cycle after edge k. This applies when rd_bank equals that bank.
- Ack: o_frame_valid drops, or switches to the other bank's frame, in the cycle after the ack edge.
- o_frame is stable while o_frame_valid is high and no ack has occurred.
- o_ready falls in the cycle after the edge on which the second bank fills while the first is still unacked.
- o_ready rises in the cycle after the ack that frees the write bank.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values immediately.

## Configuration
- SAMPLE_FRAME_BUFFER_BITREV_EN:
  - Defined: addr(wr_ptr) is the AW-bit bit-reverse of wr_ptr, so the frame is presented in radix-2 DIT input order. With DEPTH = 16, sample 1 lands in word 8.
  - Undefined: addr(wr_ptr) = wr_ptr, natural order. o_fill counts identically in both builds.

## Test plan
- Order: reset, then 16 samples 0x0001..0x0010 with no ack → o_frame_valid = 1 one cycle after the 16th accept.
  - Without macro: word k = k+1.
  - With macro: word 1 = 0x0009 and word 8 = 0x0002.
- Back-pressure: 40 consecutive samples with no ack → o_ready = 0 after the 32nd accept; samples 33..40 are dropped; o_overflow = 1. Then ack once → the first frame is released, o_frame shows the second frame, and o_ready returns to 1.
- Simultaneous events: the 16th write into bank 1 and the ack of bank 0 on the same edge → o_frame_valid stays 1, o_frame switches to bank 1's data, and o_fill = 0.
- Spurious ack: i_frame_ack pulsed with o_frame_valid = 0 → no state change; the next 16 samples still form frame 0 normally.
- Flush: i_flush after 7 samples, with i_valid also high that cycle → o_fill = 0, o_overflow = 0, o_frame_valid = 0. The following 16 samples form a complete, correct frame.
- Reset mid-frame: i_rst_n pulled low asynchronously mid-cycle after 9 samples → o_fill = 0, o_frame = 0 and o_ready = 1 immediately, without waiting for a clock edge.
